// File: rtl/siso_shift_arbiter_if.sv
// Request/serial-link bundle for siso_shift_arbiter.
// The design itself takes the slave view; producers and the link side take the master view.
interface siso_shift_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             grant_id;
  logic             frame_done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, sout, sout_valid, busy, grant_id, frame_done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, sout, sout_valid, busy, grant_id, frame_done
  );
endinterface

// File: rtl/siso_shift_arbiter.sv
// Round-robin two-requester scheduler serialising WIDTH-bit words MSB-first on one link.
// Latency: first bit one cycle after accept; readies only in IDLE. PARITY_EN appends an even-parity bit.
module siso_shift_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  siso_shift_arbiter_if.slave   bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_grant_q, last_grant_d;
  logic             grant_id_q, grant_id_d;
`ifdef PARITY_EN
  logic             par_q, par_d;
`endif

  logic             gnt0, gnt1;
  logic             take0, take1;
  logic [WIDTH-1:0] load_data;

  // Both valid: the requester that did not own the last frame wins.
  always_comb begin
    gnt1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
    gnt0 = bus.req0_valid & ~gnt1;
  end

  assign bus.req0_ready = (state_q == IDLE) & ~rst & gnt0;
  assign bus.req1_ready = (state_q == IDLE) & ~rst & gnt1;
  assign take0          = bus.req0_valid & bus.req0_ready;
  assign take1          = bus.req1_valid & bus.req1_ready;
  assign load_data      = take1 ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
`ifdef PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sreg_q       <= sreg_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
`ifdef PARITY_EN
      par_q        <= par_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    sreg_d       = sreg_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
`ifdef PARITY_EN
    par_d        = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (take0 | take1) begin
          sreg_d       = load_data;
          cnt_d        = '0;
          grant_id_d   = take1;
          last_grant_d = take1;
`ifdef PARITY_EN
          par_d        = ^load_data;
`endif
          state_d      = SHIFT;
        end
      end
      SHIFT: begin
        sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
          state_d = PAR;
`else
          state_d = GAP;
`endif
        end
      end
      PAR:     state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Link outputs decode from state registers only, so reset clears them asynchronously.
  always_comb begin
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    case (state_q)
      SHIFT: begin
        bus.sout       = sreg_q[WIDTH-1];
        bus.sout_valid = 1'b1;
      end
`ifdef PARITY_EN
      PAR: begin
        bus.sout       = par_q;
        bus.sout_valid = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.grant_id   = grant_id_q;
  assign bus.frame_done = (state_q == GAP);

endmodule

// File: tb/tb_siso_shift_arbiter.sv
// Directed bench for siso_shift_arbiter: cycle model predicts readies/timing, scoreboard queues hold serial bits and grants.
module tb_siso_shift_arbiter;

  localparam int W = 4;
`ifdef PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  siso_shift_arbiter_if #(.WIDTH(W)) bus ();
  siso_shift_arbiter #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit bitq[$];
  bit gidq[$];
  int rem = 0;      // non-IDLE cycles still expected in the current frame
  bit m_last = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pop expected bits/grants as the DUT emits them.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sout_valid === 1'b1) begin
        if (bitq.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL sout_extra: observed bit %0b expected none", bus.sout);
        end else begin
          chk("sout_bit", bus.sout, bitq.pop_front());
        end
      end else begin
        chk("sout_idle", bus.sout, 0);
      end
      if (bus.frame_done === 1'b1) begin
        if (gidq.size() == 0) begin
          n_vec++; n_err++;
          $error("FAIL frame_done_extra: observed grant %0b expected no frame", bus.grant_id);
        end else begin
          chk("grant_id", bus.grant_id, gidq.pop_front());
        end
      end
    end
  end

  task automatic step(input bit v0, input logic [W-1:0] d0, input bit v1, input logic [W-1:0] d1);
    bit e0, e1;
    logic [W-1:0] w;
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
    #1;
    chk("busy", bus.busy, rem != 0);
    chk("sout_valid", bus.sout_valid, rem > 1);
    chk("frame_done", bus.frame_done, rem == 1);
    e0 = 1'b0;
    e1 = 1'b0;
    if (rem == 0) begin
      if (v0 && v1) begin
        e1 = ~m_last;
        e0 = m_last;
      end else begin
        e0 = v0;
        e1 = v1;
      end
    end
    chk("req0_ready", bus.req0_ready, e0);
    chk("req1_ready", bus.req1_ready, e1);
    if (e0 || e1) begin
      w = e1 ? d1 : d0;
      for (int i = W - 1; i >= 0; i--) bitq.push_back(w[i]);
`ifdef PARITY_EN
      bitq.push_back(^w);
`endif
      gidq.push_back(e1);
      m_last = e1;
      rem = FLEN + 1;
    end else if (rem != 0) begin
      rem--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_hold();
    rst = 1'b1;
    #1;
    chk("rst_sout_valid", bus.sout_valid, 0);
    chk("rst_sout", bus.sout, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_req0_ready", bus.req0_ready, 0);
    chk("rst_req1_ready", bus.req1_ready, 0);
    bitq.delete();
    gidq.delete();
    rem = 0;
    m_last = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rv_busy", bus.busy, 0);
    chk("rv_sout_valid", bus.sout_valid, 0);
    chk("rv_grant_id", bus.grant_id, 0);
    chk("rv_frame_done", bus.frame_done, 0);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0);
  endtask

  initial begin
    bus.req0_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_valid = 1'b1;
    bus.req1_data  = 4'h6;
    reset_hold();
    bus.req1_valid = 1'b0;

    // Single word from req0; req1 raised and dropped while busy is never granted.
    step(1'b1, 4'b1011, 1'b0, '0);
    step(1'b0, '0, 1'b1, 4'h7);
    step(1'b0, '0, 1'b1, 4'h7);
    idle_steps(FLEN + 3);

    // Both valid: alternation starts with req0 after reset.
    reset_hold();
    for (int i = 0; i < 4 * (FLEN + 2); i++) step(1'b1, 4'hA, 1'b1, 4'h5);
    idle_steps(FLEN + 3);

    // Only req1: back-to-back frames.
    for (int i = 0; i < 3 * (FLEN + 2); i++) step(1'b0, '0, 1'b1, 4'h9);
    idle_steps(FLEN + 3);

    // Reset after two bits with req0 still pending, then full resend.
    step(1'b1, 4'b1100, 1'b0, '0);
    step(1'b1, 4'b1100, 1'b0, '0);
    #2;
    reset_hold();
    step(1'b1, 4'b1100, 1'b0, '0);
    idle_steps(FLEN + 3);

    // Parity-sensitive words and data toggling on req1 during SHIFT.
    step(1'b1, 4'b1001, 1'b0, '0);
    for (int i = 0; i < FLEN + 2; i++) step(1'b0, '0, 1'b1, (i % 2 == 0) ? 4'hA : 4'h3);
    idle_steps(FLEN + 3);

    chk("sb_bits_left", bitq.size(), 0);
    chk("sb_frames_left", gidq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
